gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SETTLE_CYCLES, default 4: wait cycles between driving a vector and sampling results; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  level; a sweep begins when sampled high in IDLE.
REQ-005 a_out  output  1  gate-block operand A.
REQ-006 b_out  output  1  gate-block operand B.
REQ-007 res_in  input  6  gate-block results; bit5..0 = AND, OR, NOT A, NAND, NOR, XOR.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 pass  output  1  high while err_count==0 after a completed sweep; cleared at sweep start.
REQ-011 err_count  output  3  number of mismatching vectors in the last sweep, 0..4.
REQ-012 fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-013 States: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-014 IDLE & start=1 -> DRIVE; idx, err_count, fail_vec and pass are cleared on that edge.
REQ-015 DRIVE, 1 cycle: a_out=idx[1], b_out=idx[0]; settle counter loaded with SETTLE_CYCLES.
REQ-016 SETTLE: decrement once per cycle; leave for CHECK when the counter reaches 0; SETTLE_CYCLES=0 goes DRIVE->CHECK directly.
REQ-017 CHECK, 1 cycle: compare res_in against expected {a&b, a|b, ~a, ~(a&b), ~(a|b), a^b} built from a_out/b_out; on any bit mismatch, increment err_count and set fail_vec[idx].
REQ-018 CHECK exit: idx<3 -> idx+1, go to DRIVE; idx==3 -> DONE.
REQ-019 DONE, 1 cycle: done=1; pass=(err_count==0); then go to IDLE.
REQ-020 Per-vector cost is SETTLE_CYCLES+2 cycles; done asserts exactly 4*(SETTLE_CYCLES+2)+1 cycles after the start-accept edge.
REQ-021 start is ignored outside IDLE; a_out and b_out hold their last values in SETTLE, CHECK, DONE and IDLE.
REQ-022 err_count, fail_vec and pass hold their values in IDLE until the next accepted start.

Reset
REQ-023 rst=1 forces IDLE immediately, regardless of the clock: idx=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-024 Reset mid-sweep discards partial results; no done pulse is produced.
REQ-025 After rst deasserts, start high on the first clock edge is accepted.

Configuration
REQ-026 Macro GATE_SWEEP_LOOP_EN.
REQ-027 Defined: DONE with start still high goes to DRIVE, not IDLE, clearing idx, err_count and fail_vec; done still pulses for one cycle per sweep.
REQ-028 Undefined: DONE always goes to IDLE, so each sweep needs start sampled high again in IDLE.

Structure
REQ-029 The shared package holds the state enum, the res_in bit-index constants (AND=5 .. XOR=0) and the vector count constant 4.
REQ-030 Sub-module gate_expect (combinational: a, b -> 6-bit expected value) is instantiated once; the FSM, counters and flags stay in gate_sweep_checker.

Verification
REQ-031 Bench drives res_in from a correct gate model; SETTLE_CYCLES=4, start pulsed -> a/b sequence 00,01,10,11; done at cycle 25; pass=1; err_count=0; fail_vec=0000.
REQ-032 Model XOR stuck at 0 -> vectors 01 and 10 fail; err_count=2; fail_vec=0110; pass=0.
REQ-033 SETTLE_CYCLES=0 -> done at cycle 9; results identical to REQ-031.
REQ-034 rst asserted during vector 2 CHECK -> all outputs 0 asynchronously; no done pulse; a fresh sweep then passes.
REQ-035 start held high throughout: without GATE_SWEEP_LOOP_EN -> done pulses every 26 cycles via IDLE; with it defined -> done pulses every 25 cycles.
REQ-036 start toggled during a sweep -> no restart; done timing unchanged.

Source files
------------

// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states, res_in bit map, vector count.
package gate_sweep_checker_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned ResWidth = 6;

    localparam int unsigned ResAnd  = 5;
    localparam int unsigned ResOr   = 4;
    localparam int unsigned ResNotA = 3;
    localparam int unsigned ResNand = 2;
    localparam int unsigned ResNor  = 1;
    localparam int unsigned ResXor  = 0;

    localparam int unsigned NumVectors = 4;

endpackage

// File: rtl/gate_expect.sv
// Golden gate results for one operand pair, packed in the same bit order as res_in.
module gate_expect
    import gate_sweep_checker_pkg::*;
(
    input  logic                a,
    input  logic                b,
    output logic [ResWidth-1:0] expected
);

    always_comb begin
        expected          = '0;
        expected[ResAnd]  = a & b;
        expected[ResOr]   = a | b;
        expected[ResNotA] = ~a;
        expected[ResNand] = ~(a & b);
        expected[ResNor]  = ~(a | b);
        expected[ResXor]  = a ^ b;
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all four a/b operand pairs through an external gate block and scores the results.
// Define GATE_SWEEP_LOOP_EN to chain sweeps back-to-back while start stays high.
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                a_out,
    output logic                b_out,
    input  logic [ResWidth-1:0] res_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2:0]          err_count,
    output logic [3:0]          fail_vec
);

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LastIdx    = 2'(NumVectors - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic [2:0]    err_q, err_d;
    logic [3:0]    fail_q, fail_d;
    logic          pass_q, pass_d;
    logic [ResWidth-1:0] expected;
    logic          mismatch;

    gate_expect u_gate_expect (
        .a        (a_q),
        .b        (b_q),
        .expected (expected)
    );

    assign mismatch = (res_in != expected);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            StDrive: begin
                a_d     = idx_q[1];
                b_d     = idx_q[0];
                cnt_d   = SettleInit;
                state_d = (SettleInit == 4'd0) ? StCheck : StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d         = err_q + 3'd1;
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    // Registered here so pass is already valid during the done pulse.
                    pass_d  = (err_d == 3'd0);
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef GATE_SWEEP_LOOP_EN
                if (start) begin
                    state_d = StDrive;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: one instance at SETTLE_CYCLES=4, one at 0.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_drv;
    logic       sel;
    logic       xor_bad;

    logic       start4, start0;
    logic       a4, b4, busy4, done4, pass4;
    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err4, err0;
    logic [3:0] fail4, fail0;
    logic [5:0] res4, res0;

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [3:0] o_fail;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Reference gate block; xor_bad models an XOR output stuck at 0.
    function automatic logic [5:0] model(input logic a, input logic b, input logic bad);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), bad ? 1'b0 : (a ^ b)};
    endfunction

    assign res4   = model(a4, b4, xor_bad);
    assign res0   = model(a0, b0, xor_bad);
    assign start4 = start_drv & ~sel;
    assign start0 = start_drv & sel;

    assign o_a    = sel ? a0    : a4;
    assign o_b    = sel ? b0    : b4;
    assign o_busy = sel ? busy0 : busy4;
    assign o_done = sel ? done0 : done4;
    assign o_pass = sel ? pass0 : pass4;
    assign o_err  = sel ? err0  : err4;
    assign o_fail = sel ? fail0 : fail4;

    gate_sweep_checker #(.SETTLE_CYCLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .a_out     (a4),
        .b_out     (b4),
        .res_in    (res4),
        .busy      (busy4),
        .done      (done4),
        .pass      (pass4),
        .err_count (err4),
        .fail_vec  (fail4)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .a_out     (a0),
        .b_out     (b0),
        .res_in    (res0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .err_count (err0),
        .fail_vec  (fail0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the start-accept edge. Returns the cycle done is seen,
    // the four a/b pairs (vector 0 in the top bits), busy in cycle 1 and pass during done.
    task automatic sweep(input int n, input bit toggle, output int dcyc,
                         output logic [7:0] seq, output logic busy1, output logic pass_d);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        dcyc   = -1;
        seq    = '0;
        busy1  = o_busy;
        pass_d = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            for (int v = 0; v < 4; v++) begin
                if (c == 2 + (n + 2) * v) seq[7 - 2 * v -: 2] = {o_a, o_b};
            end
            if (o_done) begin
                dcyc   = c;
                pass_d = o_pass;
                break;
            end
            start_drv = (toggle && c < 4 * (n + 2) - 2) ? c[0] : 1'b0;
            tick();
        end
        start_drv = 1'b0;
    endtask

    int         dcyc, period, ndone;
    logic [7:0] seq;
    logic       busy1, pass_d;

    initial begin
        rst = 1'b1; start_drv = 1'b0; sel = 1'b0; xor_bad = 1'b0;
        tick(); tick();
        check("reset_outputs_s4", {a4, b4, busy4, done4, pass4, err4, fail4}, 0);
        check("reset_outputs_s0", {a0, b0, busy0, done0, pass0, err0, fail0}, 0);
        rst = 1'b0;

        // Good gate block, start on first edge after reset release.
        sweep(4, 1'b0, dcyc, seq, busy1, pass_d);
        check("s4_done_cycle", dcyc, 25);
        check("s4_ab_sequence", seq, 8'b00_01_10_11);
        check("s4_busy_cycle1", busy1, 1);
        check("s4_pass_at_done", pass_d, 1);
        check("s4_busy_at_done", o_busy, 0);
        tick();
        check("s4_idle_hold", {o_done, o_pass, o_err, o_fail}, {1'b0, 1'b1, 3'd0, 4'b0000});

        // XOR stuck at 0: vectors 01 and 10 disagree.
        xor_bad = 1'b1;
        sweep(4, 1'b0, dcyc, seq, busy1, pass_d);
        check("xor_done_cycle", dcyc, 25);
        check("xor_pass_at_done", pass_d, 0);
        tick();
        check("xor_err_count", o_err, 2);
        check("xor_fail_vec", o_fail, 4'b0110);
        check("xor_pass_idle", o_pass, 0);
        xor_bad = 1'b0;

        // Zero settle time.
        sel = 1'b1;
        tick();
        sweep(0, 1'b0, dcyc, seq, busy1, pass_d);
        check("s0_done_cycle", dcyc, 9);
        check("s0_ab_sequence", seq, 8'b00_01_10_11);
        check("s0_pass_at_done", pass_d, 1);
        tick();
        check("s0_results", {o_pass, o_err, o_fail}, {1'b1, 3'd0, 4'b0000});
        sel = 1'b0;
        tick();

        // Reset during vector 2 CHECK (cycle 18), applied between clock edges.
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        repeat (17) tick();
        #2 rst = 1'b1;
        #1;
        check("midreset_async", {a4, b4, busy4, done4, pass4, err4, fail4}, 0);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done4) ndone++;
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done4) ndone++;
        end
        check("midreset_no_done", ndone, 0);
        sweep(4, 1'b0, dcyc, seq, busy1, pass_d);
        check("fresh_done_cycle", dcyc, 25);
        check("fresh_pass", pass_d, 1);
        tick();

        // start held high: spacing between successive done pulses.
        start_drv = 1'b1;
        dcyc = -1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (o_done) begin
                dcyc = c;
                break;
            end
        end
        check("hold_first_done_seen", dcyc >= 0, 1);
        period = -1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (o_done) begin
                period = c;
                break;
            end
        end
        start_drv = 1'b0;
`ifdef GATE_SWEEP_LOOP_EN
        check("hold_done_period", period, 25);
`else
        check("hold_done_period", period, 26);
`endif
        check("hold_pass", o_pass, 1);
        tick();
        tick();
        check("hold_back_idle", {o_busy, o_done}, 0);

        // start toggling mid-sweep must not restart it.
        sweep(4, 1'b1, dcyc, seq, busy1, pass_d);
        check("toggle_done_cycle", dcyc, 25);
        check("toggle_ab_sequence", seq, 8'b00_01_10_11);
        check("toggle_pass", pass_d, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
